// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing controller: decodes the hazard code into PC/IF-ID controls
// and sequences branch/jump flush, halt drain and the halted state.
module pipeline_ctrl #(
  parameter int HAZARD_WIDTH = 3,
  parameter int FLUSH_CYCLES = 1,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [HAZARD_WIDTH-1:0] hazard,
  input  logic                    if_write,
  input  logic                    resume,
  input  logic                    clr_cnt,
  output logic                    pc_en,
  output logic                    ifid_en,
  output logic                    ifid_flush,
  output logic                    idex_flush,
  output logic [1:0]              pc_sel,
  output logic                    halted,
  output logic                    illegal_hz,
  output logic [CNT_WIDTH-1:0]    stall_cnt,
  output logic [CNT_WIDTH-1:0]    redir_cnt
);

  typedef enum logic [1:0] {RUN, FLUSH, DRAIN, HALTED} state_t;

  localparam logic [HAZARD_WIDTH-1:0] HZ_NONE = HAZARD_WIDTH'(0);
  localparam logic [HAZARD_WIDTH-1:0] HZ_LDBR = HAZARD_WIDTH'(1);
  localparam logic [HAZARD_WIDTH-1:0] HZ_BGT  = HAZARD_WIDTH'(2);
  localparam logic [HAZARD_WIDTH-1:0] HZ_BEQ  = HAZARD_WIDTH'(3);
  localparam logic [HAZARD_WIDTH-1:0] HZ_JMP  = HAZARD_WIDTH'(4);
  localparam logic [HAZARD_WIDTH-1:0] HZ_HALT = HAZARD_WIDTH'(5);

  localparam logic [1:0] SEL_SEQ = 2'b00;
  localparam logic [1:0] SEL_BR  = 2'b01;
  localparam logic [1:0] SEL_JMP = 2'b10;

  state_t     state, state_nxt;
  logic [2:0] cyc, cyc_nxt;
  logic       stall_inc, redir_inc, illegal_set;
  logic       pc_en_c, ifid_en_c, ifid_flush_c, idex_flush_c, halted_c;
  logic [1:0] pc_sel_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cyc   <= '0;
    end else begin
      state <= state_nxt;
      cyc   <= cyc_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cyc_nxt      = cyc;
    pc_en_c      = 1'b0;
    ifid_en_c    = 1'b0;
    ifid_flush_c = 1'b0;
    idex_flush_c = 1'b0;
    pc_sel_c     = SEL_SEQ;
    halted_c     = 1'b0;
    stall_inc    = 1'b0;
    redir_inc    = 1'b0;
    illegal_set  = 1'b0;
    unique case (state)
      RUN: begin
        case (hazard)
          HZ_NONE: begin
            pc_en_c   = 1'b1;
            ifid_en_c = 1'b1;
          end
          HZ_LDBR, HZ_BGT, HZ_BEQ, HZ_JMP: begin
            if (hazard == HZ_LDBR && if_write) begin
              idex_flush_c = 1'b1;
              stall_inc    = 1'b1;
            end else begin
              // Taken redirect: IF/ID is zeroed, so its enable stays low.
              pc_en_c      = 1'b1;
              pc_sel_c     = (hazard == HZ_JMP) ? SEL_JMP : SEL_BR;
              ifid_flush_c = 1'b1;
              idex_flush_c = 1'b1;
              redir_inc    = 1'b1;
              cyc_nxt      = 3'(FLUSH_CYCLES);
              state_nxt    = FLUSH;
            end
          end
          HZ_HALT: begin
            ifid_flush_c = 1'b1;
            cyc_nxt      = 3'(DRAIN_CYCLES);
            state_nxt    = DRAIN;
          end
          default: begin
            pc_en_c     = 1'b1;
            ifid_en_c   = 1'b1;
            illegal_set = 1'b1;
          end
        endcase
      end
      FLUSH: begin
        pc_en_c      = 1'b1;
        ifid_en_c    = 1'b1;
        ifid_flush_c = 1'b1;
        cyc_nxt      = cyc - 3'd1;
        if (cyc == 3'd1) state_nxt = RUN;
      end
      DRAIN: begin
        ifid_flush_c = 1'b1;
        idex_flush_c = 1'b1;
        cyc_nxt      = cyc - 3'd1;
        if (cyc == 3'd1) state_nxt = HALTED;
      end
      HALTED: begin
        halted_c = 1'b1;
        if (resume) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // Mealy outputs would otherwise follow hazard while reset is held.
  assign pc_en      = rst_n & pc_en_c;
  assign ifid_en    = rst_n & ifid_en_c;
  assign ifid_flush = rst_n & ifid_flush_c;
  assign idex_flush = rst_n & idex_flush_c;
  assign pc_sel     = rst_n ? pc_sel_c : 2'b00;
  assign halted     = rst_n & halted_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt  <= '0;
      redir_cnt  <= '0;
      illegal_hz <= 1'b0;
    end else begin
      if (illegal_set) illegal_hz <= 1'b1;
      if (clr_cnt) begin
        stall_cnt <= '0;
        redir_cnt <= '0;
      end else begin
        if (stall_inc && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
        if (redir_inc && redir_cnt != '1) redir_cnt <= redir_cnt + 1'b1;
      end
    end
  end

endmodule
